// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word, range-checks
// the immediate, and queues {err, word} in a 2-entry valid/ready FIFO.
module inst_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  fn3,
    input  logic [6:0]  fn7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instOut,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam logic [31:0] NOP_WORD = 32'h00000013;

    logic signed [31:0] simm;
    logic [31:0]        enc_word;
    logic               illegal;
    logic [32:0]        entry_in;
    logic [32:0]        mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               push;
    logic               pop;
    logic [32:0]        head;

    assign simm = imm;

    always_comb begin
        enc_word = '0;
        illegal  = 1'b0;
        case (fmt)
            3'd0: enc_word = {fn7, rs2, rs1, fn3, rd, opcode};
            3'd1: begin
                enc_word = {imm[11:0], rs1, fn3, rd, opcode};
                illegal  = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            3'd2: begin
                enc_word = {imm[11:5], rs2, rs1, fn3, imm[4:0], opcode};
                illegal  = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            3'd3: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, fn3, imm[4:1], imm[11], opcode};
                illegal  = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
            end
            3'd4: begin
                enc_word = {imm[31:12], rd, opcode};
                illegal  = (imm[11:0] != 12'd0);
            end
            3'd5: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                illegal  = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
            end
            default: illegal = 1'b1;
        endcase
        if (opcode[1:0] != 2'b11) begin
            illegal = 1'b1;
        end
    end

    assign entry_in  = illegal ? {1'b1, NOP_WORD} : {1'b0, enc_word};
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            err_cnt <= 8'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry_in;
                wr_ptr      <= ~wr_ptr;
                if (illegal && (err_cnt != 8'hFF)) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // When empty, the slot behind rd_ptr is the one just popped, so outputs hold it.
    assign head = (count == 2'd0) ? mem[~rd_ptr] : mem[rd_ptr];
    assign {err, instOut} = head;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder: encoding, FIFO handshakes,
// immediate range errors, counter saturation and asynchronous reset.
module tb_inst_encoder;

    typedef struct {
        logic [2:0]  f;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  fn3;
    logic [6:0]  fn7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instOut;
    logic        err;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .fn3(fn3), .fn7(fn7), .imm(imm), .out_valid(out_valid),
        .out_ready(out_ready), .instOut(instOut), .err(err), .err_cnt(err_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input vec_t v);
        fmt = v.f; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        fn3 = v.f3; fn7 = v.f7; imm = v.imm;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; fn3 = '0; fn7 = '0; imm = '0;
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("[TB] FAIL rst_err_cnt: got %0d want 0", err_cnt); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (instOut !== 32'h0) begin failures++; $display("[TB] FAIL rst_instOut: got %h want 00000000", instOut); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL rst_err: got %b want 0", err); end
        tick();
    endtask

    // Words pushed back to back with out_ready high; each appears one cycle after acceptance.
    task automatic run_stream(input string name, input vec_t vecs[4]);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_vec(vecs[i]);
            in_valid = 1'b1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL %s_in_ready[%0d]: got %b want 1", name, i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL %s_out_valid[%0d]: got %b want 1", name, i, out_valid); end
            checks++; if (instOut !== vecs[i].exp) begin failures++; $display("[TB] FAIL %s_word[%0d]: got %h want %h", name, i, instOut, vecs[i].exp); end
            checks++; if (err !== vecs[i].e) begin failures++; $display("[TB] FAIL %s_err[%0d]: got %b want %b", name, i, err, vecs[i].e); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL %s_drain: got %b want 0", name, out_valid); end
    endtask

    task automatic test_round_trip;
        vec_t v[4];
        v[0] = '{3'd0, 7'h33, 5'd18, 5'd9,  5'd8,  3'd0, 7'd0, 32'd0,   32'h00848933, 1'b0};
        v[1] = '{3'd1, 7'h13, 5'd9,  5'd0,  5'd0,  3'd0, 7'd0, 32'h101, 32'h10100493, 1'b0};
        v[2] = '{3'd2, 7'h23, 5'd0,  5'd5,  5'd8,  3'd2, 7'd0, 32'd4,   32'h0082a223, 1'b0};
        v[3] = '{3'd3, 7'h63, 5'd0,  5'd24, 5'd20, 3'd6, 7'd0, 32'd8,   32'h014c6463, 1'b0};
        run_stream("rt", v);
    endtask

    task automatic test_jumps_upper;
        vec_t v[4];
        v[0] = '{3'd1, 7'h67, 5'd1,  5'd1, 5'd0, 3'd0, 7'd0, 32'd2047,       32'h7ff080e7, 1'b0};
        v[1] = '{3'd5, 7'h6f, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0, 32'd0,          32'h0000006f, 1'b0};
        v[2] = '{3'd4, 7'h37, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0, 32'h87237000,   32'h872370b7, 1'b0};
        v[3] = '{3'd4, 7'h17, 5'd18, 5'd0, 5'd0, 3'd0, 7'd0, 32'h10000000,   32'h10000917, 1'b0};
        run_stream("ju", v);
    endtask

    task automatic test_boundaries;
        vec_t v[4];
        v[0] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000, 32'h80000063, 1'b0};
        v[1] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,     32'h7e000fe3, 1'b0};
        v[2] = '{3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000013, 1'b0};
        v[3] = '{3'd5, 7'h6f, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000FFFFE, 32'h7ffff06f, 1'b0};
        run_stream("bd", v);
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("[TB] FAIL bd_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_back_to_back;
        vec_t a, b, c;
        a = '{3'd0, 7'h33, 5'd18, 5'd9,  5'd8, 3'd0, 7'd0, 32'd0,   32'h00848933, 1'b0};
        b = '{3'd1, 7'h13, 5'd9,  5'd0,  5'd0, 3'd0, 7'd0, 32'h101, 32'h10100493, 1'b0};
        c = '{3'd2, 7'h23, 5'd0,  5'd5,  5'd8, 3'd2, 7'd0, 32'd4,   32'h0082a223, 1'b0};
        out_ready = 1'b0;
        drive_vec(a); in_valid = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready1: got %b want 1", in_ready); end
        checks++; if (instOut !== a.exp) begin failures++; $display("[TB] FAIL bp_head1: got %h want %h", instOut, a.exp); end
        drive_vec(b);
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_full: got %b want 0", in_ready); end
        drive_vec(c);
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_held_ready: got %b want 0", in_ready); end
        checks++; if (instOut !== a.exp) begin failures++; $display("[TB] FAIL bp_held_head: got %h want %h", instOut, a.exp); end
        out_ready = 1'b1;
        tick();
        checks++; if (instOut !== b.exp) begin failures++; $display("[TB] FAIL bp_pop_b: got %h want %h", instOut, b.exp); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_reopen: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (instOut !== c.exp) begin failures++; $display("[TB] FAIL bp_pop_c: got %h want %h", instOut, c.exp); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_c_valid: got %b want 1", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_errors;
        vec_t v[11];
        logic [7:0] ecnt[11];
        v[0]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7,        32'h00000013, 1'b1}; ecnt[0]  = 8'd1;
        v[1]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        32'h00500093, 1'b0}; ecnt[1]  = 8'd1;
        v[2]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h00000013, 1'b1}; ecnt[2]  = 8'd2;
        v[3]  = '{3'd6, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0,        32'h00000013, 1'b1}; ecnt[3]  = 8'd3;
        v[4]  = '{3'd0, 7'h30, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0,        32'h00000013, 1'b1}; ecnt[4]  = 8'd4;
        v[5]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,     32'h00000013, 1'b1}; ecnt[5]  = 8'd5;
        v[6]  = '{3'd5, 7'h6f, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 32'h00000013, 1'b1}; ecnt[6]  = 8'd6;
        v[7]  = '{3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h00000013, 1'b1}; ecnt[7]  = 8'd7;
        v[8]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFF7FF, 32'h00000013, 1'b1}; ecnt[8]  = 8'd8;
        v[9]  = '{3'd5, 7'h6f, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        32'h00000013, 1'b1}; ecnt[9]  = 8'd9;
        v[10] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFEFFE, 32'h00000013, 1'b1}; ecnt[10] = 8'd10;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive_vec(v[i]);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            checks++; if (instOut !== v[i].exp) begin failures++; $display("[TB] FAIL err_word[%0d]: got %h want %h", i, instOut, v[i].exp); end
            checks++; if (err !== v[i].e) begin failures++; $display("[TB] FAIL err_flag[%0d]: got %b want %b", i, err, v[i].e); end
            checks++; if (err_cnt !== ecnt[i]) begin failures++; $display("[TB] FAIL err_cnt[%0d]: got %0d want %0d", i, err_cnt, ecnt[i]); end
            tick();
        end
    endtask

    task automatic test_saturation;
        vec_t bad;
        bad = '{3'd7, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h00000013, 1'b1};
        out_ready = 1'b1;
        drive_vec(bad);
        in_valid = 1'b1;
        repeat (244) tick();
        checks++; if (err_cnt !== 8'd254) begin failures++; $display("[TB] FAIL sat_254: got %0d want 254", err_cnt); end
        repeat (16) tick();
        in_valid = 1'b0;
        checks++; if (err_cnt !== 8'd255) begin failures++; $display("[TB] FAIL sat_255: got %0d want 255", err_cnt); end
        tick();
    endtask

    task automatic test_reset_mid;
        vec_t bad, good, last;
        bad  = '{3'd6, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,   32'h00000013, 1'b1};
        good = '{3'd1, 7'h13, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'h101, 32'h10100493, 1'b0};
        last = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,   32'h00500093, 1'b0};
        apply_reset();
        out_ready = 1'b1;
        drive_vec(bad); in_valid = 1'b1;
        repeat (5) tick();
        out_ready = 1'b0;
        drive_vec(good);
        repeat (3) tick();
        in_valid = 1'b0;
        checks++; if (err_cnt !== 8'd5) begin failures++; $display("[TB] FAIL rm_pre_cnt: got %0d want 5", err_cnt); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rm_pre_full: got %b want 0", in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rm_out_valid: got %b want 0", out_valid); end
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("[TB] FAIL rm_err_cnt: got %0d want 0", err_cnt); end
        #2;
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rm_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        drive_vec(last); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (instOut !== last.exp) begin failures++; $display("[TB] FAIL rm_word: got %h want %h", instOut, last.exp); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL rm_valid: got %b want 1", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rm_only_one: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_jumps_upper();
        test_boundaries();
        test_back_to_back();
        test_errors();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
